// File: rtl/bp_me_pkg.sv
// Shared memory-message types for the host-side load path and the source ids
// used to steer in-order responses back to the loader that issued the command.
package bp_me_pkg;

  localparam int paddr_width_gp      = 40;
  localparam int cce_block_width_gp  = 64;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_cce_mem_msg_type_e;

  typedef enum logic {
    e_load_src_cfg = 1'b0,
    e_load_src_nbf = 1'b1
  } bp_load_src_e;

  typedef enum logic {
    e_arb_idle   = 1'b0,
    e_arb_locked = 1'b1
  } bp_load_arb_state_e;

  typedef struct packed {
    bp_cce_mem_msg_type_e            msg_type;
    logic [2:0]                      size;
    logic [paddr_width_gp-1:0]       addr;
    logic [cce_block_width_gp-1:0]   data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with a combinational head. ready_o reflects
// occupancy only, so a same-cycle pop never makes room for a push.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r;
  logic [ptr_w_lp-1:0] rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                w_push;
  logic                w_pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign w_push  = v_i & ready_o;
  assign w_pop   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (w_push) wptr_r <= ptr_inc(wptr_r);
      if (w_pop)  rptr_r <= ptr_inc(rptr_r);
      count_r <= count_r + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);
    end
  end

endmodule

// File: rtl/bp_me_io_load_arbiter.sv
// Round-robin 2:1 merge of the config and NBF loader command streams onto one
// memory channel; a tag FIFO of source ids routes in-order responses back.
module bp_me_io_load_arbiter
  import bp_me_pkg::*;
#(
  parameter int els_p               = 8,
  parameter bit check_orphan_resp_p = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic [cce_mem_msg_width_gp-1:0] cfg_cmd_i,
  input  logic                            cfg_cmd_v_i,
  output logic                            cfg_cmd_ready_o,
  output logic [cce_mem_msg_width_gp-1:0] cfg_resp_o,
  output logic                            cfg_resp_v_o,
  input  logic                            cfg_resp_ready_i,

  input  logic [cce_mem_msg_width_gp-1:0] nbf_cmd_i,
  input  logic                            nbf_cmd_v_i,
  output logic                            nbf_cmd_ready_o,
  output logic [cce_mem_msg_width_gp-1:0] nbf_resp_o,
  output logic                            nbf_resp_v_o,
  input  logic                            nbf_resp_ready_i,

  output logic [cce_mem_msg_width_gp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_gp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,

  output logic                            idle_o
);

  bp_load_arb_state_e state_r, state_n;
  bp_load_src_e       lock_src_r, lock_src_n;
  bp_load_src_e       last_grant_r, last_grant_n;

  bp_load_src_e w_grant;
  bp_load_src_e w_head;
  logic         w_cmd_v;
  logic         w_hs;
  logic         w_tag_ready;
  logic         w_tag_full;
  logic         w_tag_v;
  logic         w_tag_empty;
  logic         w_head_v;
  logic [0:0]   w_push_tag;
  logic [0:0]   w_head_bits;

  assign w_tag_full  = ~w_tag_ready;
  assign w_tag_empty = ~w_tag_v;

  always_comb begin
    w_grant      = e_load_src_cfg;
    w_cmd_v      = 1'b0;
    state_n      = state_r;
    lock_src_n   = lock_src_r;
    last_grant_n = last_grant_r;

    case (state_r)
      e_arb_locked: begin
        w_grant = lock_src_r;
        w_cmd_v = ((lock_src_r == e_load_src_cfg) ? cfg_cmd_v_i : nbf_cmd_v_i) & ~w_tag_full;
      end
      default: begin
        // A contest goes to whoever did not win last; a lone requester always wins.
        if (cfg_cmd_v_i & nbf_cmd_v_i)
          w_grant = (last_grant_r == e_load_src_nbf) ? e_load_src_cfg : e_load_src_nbf;
        else if (nbf_cmd_v_i)
          w_grant = e_load_src_nbf;
        else
          w_grant = e_load_src_cfg;
        w_cmd_v = (cfg_cmd_v_i | nbf_cmd_v_i) & ~w_tag_full;
      end
    endcase

    if (reset_i) w_cmd_v = 1'b0;
    w_hs = w_cmd_v & mem_cmd_ready_i;

    if (w_hs) begin
      state_n      = e_arb_idle;
      last_grant_n = w_grant;
    end else if (w_cmd_v) begin
      state_n    = e_arb_locked;
      lock_src_n = w_grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_arb_idle;
      lock_src_r   <= e_load_src_cfg;
      last_grant_r <= e_load_src_nbf;
    end else begin
      state_r      <= state_n;
      lock_src_r   <= lock_src_n;
      last_grant_r <= last_grant_n;
    end
  end

  assign mem_cmd_v_o     = w_cmd_v;
  assign mem_cmd_o       = (w_grant == e_load_src_cfg) ? cfg_cmd_i : nbf_cmd_i;
  assign cfg_cmd_ready_o = w_hs & (w_grant == e_load_src_cfg);
  assign nbf_cmd_ready_o = w_hs & (w_grant == e_load_src_nbf);

  assign w_push_tag = w_grant;
  assign w_head     = bp_load_src_e'(w_head_bits);
  assign w_head_v   = w_tag_v & ~reset_i;

  bsg_fifo_1r1w_small #(
    .width_p (1),
    .els_p   (els_p)
  ) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_hs),
    .ready_o (w_tag_ready),
    .data_i  (w_push_tag),
    .v_o     (w_tag_v),
    .data_o  (w_head_bits),
    .yumi_i  (mem_resp_yumi_o)
  );

  assign cfg_resp_o      = mem_resp_i;
  assign nbf_resp_o      = mem_resp_i;
  assign cfg_resp_v_o    = mem_resp_v_i & w_head_v & (w_head == e_load_src_cfg);
  assign nbf_resp_v_o    = mem_resp_v_i & w_head_v & (w_head == e_load_src_nbf);
  assign mem_resp_yumi_o = (cfg_resp_v_o & cfg_resp_ready_i) | (nbf_resp_v_o & nbf_resp_ready_i);

  assign idle_o = w_tag_empty & ~mem_cmd_v_o;

  // A response with no outstanding tag has nowhere to go and is left unconsumed.
  if (check_orphan_resp_p) begin : g_orphan_chk
    always_ff @(posedge clk_i) begin
      assert (reset_i || !(mem_resp_v_i && w_tag_empty))
        else $error("bp_me_io_load_arbiter: response with no outstanding command");
    end
  end

endmodule

// File: doc/bp_me_io_load_arbiter.md
Name: bp_me_io_load_arbiter

Overview:
- Sequential 2:1 arbiter that merges the CCE config loader and the NBF loader command streams onto a single bp_cce_mem_msg_s channel feeding the host-side bp_me_cce_to_mem_link_bidir.
- Returns each in-order response to the source that issued the matching command.
- Replaces the fixed-priority combinational mux, so both loaders may overlap safely with up to els_p requests in flight.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr/cce_block widths for bp_cce_mem_msg_s.
- els_p, 8, max outstanding commands (tag FIFO depth); must be >= 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cfg_cmd_i  in  cce_mem_msg_width_lp  config loader command
- cfg_cmd_v_i  in  1  cfg command valid
- cfg_cmd_ready_o  out  1  cfg command ready
- cfg_resp_o  out  cce_mem_msg_width_lp  response to cfg loader
- cfg_resp_v_o  out  1  cfg response valid
- cfg_resp_ready_i  in  1  cfg loader ready for response
- nbf_cmd_i / nbf_cmd_v_i / nbf_cmd_ready_o  in/in/out  msg/1/1  NBF loader command channel
- nbf_resp_o / nbf_resp_v_o / nbf_resp_ready_i  out/out/in  msg/1/1  NBF loader response channel
- mem_cmd_o  out  cce_mem_msg_width_lp  merged command to host link
- mem_cmd_v_o  out  1  merged command valid
- mem_cmd_ready_i  in  1  host link ready
- mem_resp_i  in  cce_mem_msg_width_lp  response from host link (in order)
- mem_resp_v_i  in  1  response valid
- mem_resp_yumi_o  out  1  response consumed
- idle_o  out  1  no commands outstanding and none pending

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous, active-high.
- Reset values: mem_cmd_v_o=0, both cmd_ready_o=0, both resp_v_o=0, mem_resp_yumi_o=0, idle_o=1, tag FIFO empty, lock clear, last_grant_r=nbf (cfg wins first contest).
- States: IDLE (no lock) and LOCKED (grant held in lock_src_r).
  - IDLE: if tag FIFO not full and any source valid, grant by round-robin against last_grant_r; a lone requester always wins.
  - IDLE -> LOCKED: the grant is offered but mem_cmd_ready_i=0 that cycle.
  - LOCKED: mem_cmd_v_o and mem_cmd_o come from lock_src_r regardless of the other source; the grant must not change until handshake.
  - Handshake = mem_cmd_v_o & mem_cmd_ready_i. On handshake: push source id into the tag FIFO, set last_grant_r to the granted source, clear the lock (return to IDLE).
- Command path:
  - mem_cmd_v_o never depends combinationally on mem_cmd_ready_i.
  - A source's cmd_ready_o = granted & mem_cmd_ready_i & ~tag_full.
  - Source cmd payloads must stay stable while their valid is high.
  - Latency is zero cycles (combinational pass-through of payload).
- Tag FIFO full: no new grant and mem_cmd_v_o=0. A same-cycle pop does not free a slot for a push that cycle.
- Response path:
  - Head tag selects the destination: resp_o = mem_resp_i, resp_v_o = mem_resp_v_i & ~tag_empty & (head==src).
  - mem_resp_yumi_o = selected resp_v_o & that source's resp_ready_i.
  - Pop the tag on yumi. The non-selected source's resp_v_o is 0.
- Simultaneous command push and response pop on a non-full FIFO: both happen and occupancy is unchanged.
- Response with tag FIFO empty: mem_resp_yumi_o=0 (not consumed); a nonsynth assertion fires an error.
- idle_o = tag_empty & ~mem_cmd_v_o.
- Reset mid-transaction: the lock and tags are discarded. Any in-flight responses are the integrator's responsibility; the bench resets the link as well.

Decomposition:
- Source-id enum (e_load_src_cfg=0, e_load_src_nbf=1) goes in bp_me_pkg.
- Tag store is a bsg_fifo_1r1w_small instance (width 1, els_p).
- The round-robin/lock logic stays inline; no further sub-modules.

Test Plan:
- Only cfg issues 3 writes with mem_cmd_ready_i=1 -> 3 back-to-back handshakes; 3 responses return, all to cfg; nbf_resp_v_o stays 0; idle_o=1 after the third yumi.
- Both valid every cycle with ready=1 -> grants alternate cfg, nbf, cfg, nbf; responses route in the same order.
- nbf granted with ready=0 for 4 cycles while cfg asserts valid -> mem_cmd_o holds nbf payload; the nbf handshake happens on cycle 5; cfg is granted next.
- Issue els_p=8 commands without responses -> the 9th is blocked (mem_cmd_v_o=0, ready_o=0). Return 1 response -> the 9th issues the following cycle.
- Head tag=cfg, cfg_resp_ready_i=0, mem_resp_v_i=1 -> yumi=0 and the response is held. Raise ready -> yumi=1 and the pop occurs.
- mem_resp_v_i=1 with the FIFO empty -> yumi=0 and the assertion fires. Assert reset_i mid-stream -> next cycle all valids are 0 and idle_o=1.
